// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
// Two-direction intersection controller (north-south vs east-west).
// Moore FSM: a direction stays green for at least MIN_GREEN cycles and yields
// only when the opposing sensor reports a car; every handoff passes through
// CLEAR all-red cycles. Lamps are registered and decoded from the next state,
// so they always match the state register and never depend on inputs directly.
//
// Ports:
//   clock  - system clock, rising-edge active
//   reset  - asynchronous, active-high; forces NS green
//   EWCar  - east-west car present (level, synchronous to clock)
//   NSCar  - north-south car present (level, synchronous to clock)
//   EWLite - east-west green lamp (1 = green, 0 = red), registered
//   NSLite - north-south green lamp (1 = green, 0 = red), registered
module traffic_light_ctrl #(
  parameter int MIN_GREEN = 4,
  parameter int CLEAR     = 2,
  parameter int CNT_W     = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic EWCar,
  input  logic NSCar,
  output logic EWLite,
  output logic NSLite
);

  typedef enum logic [1:0] {
    NS_GREEN = 2'b00,
    NS_CLEAR = 2'b01,
    EW_GREEN = 2'b10,
    EW_CLEAR = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Next-state and dwell-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      NS_GREEN: begin
        // Yield only once matured and only if east-west is waiting right now.
        if ((cnt_r >= GREEN_LAST) && EWCar) begin
          state_s = NS_CLEAR;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r < GREEN_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      NS_CLEAR: begin
        if (cnt_r == CLEAR_LAST) begin
          state_s = EW_GREEN;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      EW_GREEN: begin
        if ((cnt_r >= GREEN_LAST) && NSCar) begin
          state_s = EW_CLEAR;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r < GREEN_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_s = cnt_r;
        end
      end
      EW_CLEAR: begin
        if (cnt_r == CLEAR_LAST) begin
          state_s = NS_GREEN;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        // Any corrupted encoding falls back to the reset state.
        state_s = NS_GREEN;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and lamp registers; lamps decode the state being entered
  // so they line up with the state register every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= NS_GREEN;
      cnt_r   <= CNT_ZERO;
      NSLite  <= 1'b1;
      EWLite  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      NSLite  <= (state_s == NS_GREEN);
      EWLite  <= (state_s == EW_GREEN);
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl (MIN_GREEN=4, CLEAR=2).
// Expected lamp pairs {NSLite, EWLite} are pushed into a scoreboard queue when
// the inputs for a cycle are driven and popped when the DUT output is sampled
// 1 time unit after the rising edge.
module tb_traffic_light_ctrl;

  logic clock;
  logic reset;
  logic EWCar;
  logic NSCar;
  logic EWLite;
  logic NSLite;

  int n_checks;
  int n_fails;

  logic [1:0] exp_q[$];

  traffic_light_ctrl #(
    .MIN_GREEN(4),
    .CLEAR    (2),
    .CNT_W    (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .EWCar (EWCar),
    .NSCar (NSCar),
    .EWLite(EWLite),
    .NSLite(NSLite)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare current lamps against the oldest scoreboard entry, plus safety.
  task automatic check_now(input string tag);
    logic [1:0] exp;
    logic [1:0] got;
    got = {NSLite, EWLite};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: scoreboard empty, observed %b expected an entry", tag, got);
    end else begin
      exp = exp_q.pop_front();
      n_checks++;
      assert (got === exp) else begin
        n_fails++;
        $error("FAIL %s: observed {NS,EW}=%b expected %b", tag, got, exp);
      end
    end
    n_checks++;
    assert (!(NSLite === 1'b1 && EWLite === 1'b1)) else begin
      n_fails++;
      $error("FAIL %s_safety: observed {NS,EW}=%b expected not 11", tag, got);
    end
  endtask

  // Drive inputs for one cycle, queue the expected post-edge lamps, then check.
  task automatic step(input logic ew, input logic ns, input logic [1:0] exp,
                      input string tag);
    EWCar = ew;
    NSCar = ns;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    check_now(tag);
  endtask

  // Reset while the clock runs, then release just after an edge so the next
  // rising edge is the first counted cycle. Lamps must read NS green at once.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    exp_q.push_back(2'b10);
    check_now(tag);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(2'b10);
    check_now({tag, "_release"});
  endtask

  localparam logic [1:0] NS_ON = 2'b10;
  localparam logic [1:0] EW_ON = 2'b01;
  localparam logic [1:0] ALL_R = 2'b00;

  initial begin
    logic [1:0] exp;
    int c;
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b0;
    EWCar    = 1'b0;
    NSCar    = 1'b0;

    // Reset asserted before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(NS_ON);
    check_now("reset_no_clock");
    @(posedge clock);
    #1;

    // Basic handoff: EWCar waiting from release.
    EWCar = 1'b1;
    reset = 1'b0;
    exp_q.push_back(NS_ON);
    check_now("handoff_c0");
    step(1'b1, 1'b0, NS_ON, "handoff_c1");
    step(1'b1, 1'b0, NS_ON, "handoff_c2");
    step(1'b1, 1'b0, NS_ON, "handoff_c3");
    step(1'b1, 1'b0, ALL_R, "handoff_c4");
    step(1'b1, 1'b0, ALL_R, "handoff_c5");
    step(1'b1, 1'b0, EW_ON, "handoff_c6");
    step(1'b1, 1'b0, EW_ON, "handoff_c7");

    // Short pulse: request present only while NS is still immature.
    EWCar = 1'b0;
    pulse_reset("pulse_reset");
    step(1'b1, 1'b0, NS_ON, "pulse_e1");
    step(1'b1, 1'b0, NS_ON, "pulse_e2");
    step(1'b1, 1'b0, NS_ON, "pulse_e3");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, NS_ON, "pulse_after");

    // Continuous demand on both sides: 12-cycle period 4 NS / 2 red / 4 EW / 2 red.
    EWCar = 1'b1;
    NSCar = 1'b1;
    pulse_reset("alt_reset");
    for (int k = 1; k <= 43; k++) begin
      c = k % 12;
      if (c < 4)       exp = NS_ON;
      else if (c < 6)  exp = ALL_R;
      else if (c < 10) exp = EW_ON;
      else             exp = ALL_R;
      step(1'b1, 1'b1, exp, "alternate");
    end

    // Now mid EW green (cycle 43 -> position 7). Reset between edges.
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(NS_ON);
    check_now("reset_mid_ew");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, NS_ON, "reset_hold");

    // Idle: no cars, NS stays green.
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, NS_ON, "idle");

    // Late request on a matured NS green: yields at the very next edge.
    step(1'b1, 1'b0, ALL_R, "late_clear0");
    step(1'b0, 1'b0, ALL_R, "late_clear1");
    step(1'b0, 1'b1, EW_ON, "late_ew");
    // EW's own car is ignored; no NS car means EW holds.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, EW_ON, "ew_hold");
    // Matured EW yields to an NS request.
    step(1'b0, 1'b1, ALL_R, "ew_yield0");
    step(1'b1, 1'b1, ALL_R, "ew_yield1");
    step(1'b0, 1'b0, NS_ON, "back_ns");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-direction intersection controller (north-south vs east-west) driven by car-presence sensors. Moore FSM with a guaranteed minimum green dwell and an all-red clearance interval between greens. Sits between the road sensor inputs and the lamp drivers. One lamp output per direction; 1 = green, 0 = red.

Parameters:
MIN_GREEN, 4, minimum cycles a direction stays green before it may yield (legal range 1..255)
CLEAR, 2, all-red clearance cycles between greens (legal range 1..255)
CNT_W, 8, dwell counter width; must hold max(MIN_GREEN, CLEAR)-1

Ports:
clock  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high; forces the NS-green state
EWCar  input  1  east-west car present (synchronous to clock, level-sensitive)
NSCar  input  1  north-south car present (synchronous to clock, level-sensitive)
EWLite output 1  east-west green lamp (registered)
NSLite output 1  north-south green lamp (registered)

Behaviour:
- One clock; reset is asynchronous and active-high.
- States: NS_GREEN, NS_CLEAR, EW_GREEN, EW_CLEAR. Outputs decode from the state register only (Moore, no input-to-output path).
  - NS_GREEN: NSLite=1, EWLite=0.
  - EW_GREEN: EWLite=1, NSLite=0.
  - NS_CLEAR and EW_CLEAR: both 0.
- Never both lamps 1, in any cycle, including during and after reset.
- Reset asserted at any time: immediately (no clock needed) state=NS_GREEN, cnt=0, NSLite=1, EWLite=0. Held while reset=1. The first rising edge after release is the first counted cycle.
- Dwell counter cnt is cleared to 0 on every state entry.
- NS_GREEN, at each rising edge:
  - cnt >= MIN_GREEN-1 and EWCar=1: go to NS_CLEAR, cnt<=0.
  - Otherwise: cnt saturating-increments, stopping at MIN_GREEN-1.
- EW_GREEN: symmetric, using NSCar and going to EW_CLEAR.
- The green lasts exactly MIN_GREEN cycles when the opposing car is already waiting. It lasts indefinitely while there is no opposing car; NSCar/EWCar for the green direction itself are ignored.
- NS_CLEAR, at each rising edge:
  - cnt == CLEAR-1: go to EW_GREEN, cnt<=0.
  - Otherwise: cnt++.
  - Clearance lasts exactly CLEAR cycles regardless of inputs.
- EW_CLEAR: same, but returns to NS_GREEN.
- Opposing car seen during clearance: no effect; the pending transition completes.
- Both cars present: the green direction yields once matured. Continuous demand on both sides gives strict alternation: MIN_GREEN green, CLEAR red, and so on.
- Opposing car that drops before maturity: no transition. The request is level-sampled only at the deciding edge.
- No latching of requests; a pulse shorter than the remaining dwell is lost (intended).
- Illegal or unreachable state encodings recover to NS_GREEN on the next edge.

Test Plan:
- Reset: reset=1 mid-EW_GREEN with no clock edge → NSLite=1, EWLite=0 immediately; hold 3 cycles → unchanged.
- Idle: release reset, EWCar=0, NSCar=0 for 20 cycles → NSLite=1 all 20 cycles, EWLite=0.
- Basic handoff (MIN_GREEN=4, CLEAR=2): EWCar=1 from reset release → NSLite=1 for cycles 0-3, both 0 for cycles 4-5, EWLite=1 from cycle 6.
- Late request: EWCar=1 asserted at cycle 10 of NS_GREEN → NSLite drops after edge 10, EWLite rises after edge 12.
- Short pulse: EWCar=1 only during cycle 1 → NS stays green, no clearance entered.
- Alternation and safety: EWCar=NSCar=1 constantly for 40 cycles → period of 12 cycles (4 NS, 2 red, 4 EW, 2 red). Assertion !(EWLite && NSLite) holds on every cycle of every test.
